// File: rtl/branch_predict_resolve.sv
// -----------------------------------------------------------------------------
// branch_predict_resolve
//
// Direction predictor plus branch resolution for the RAT pipeline.
// The predict side (decode) indexes a table of saturating counters with the PC,
// optionally XOR-ed with a global history register (gshare). The resolve side
// (execute) evaluates the branch type against the C/Z flags, flags
// mispredicts, trains the table and history, and keeps saturating statistics.
//
// Ports:
//   CLK            rising-edge clock
//   RST_N          asynchronous active-low reset
//   PRED_PC        PC of the instruction in decode
//   PRED_TAKEN     predicted direction (combinational)
//   PRED_IDX       table index used, carried down the pipe to RES_IDX
//   RES_VALID      resolve request this cycle
//   RES_IDX        table index captured at predict time
//   BRANCH_TYPE    0 none, 1 BRCC, 2 BRCS, 3 BREQ, 4 BRN, 5 BRNE, 6 CALL,
//                  7 RET, 8 RETID, 9 RETIE, A-F reserved
//   C, Z           flags at execute
//   RES_PREDICTED  prediction carried with the instruction
//   BRANCH_TAKEN   actual direction (combinational, not gated by RES_VALID)
//   BRANCH_MISS    RES_VALID & (RES_PREDICTED ^ BRANCH_TAKEN)
//   CLR_STATS      synchronous clear of the statistics counters
//   BR_COUNT       resolved conditional branches (saturating)
//   MISS_COUNT     mispredicts of all types (saturating)
// -----------------------------------------------------------------------------
module branch_predict_resolve #(
    parameter int PC_W   = 10,
    parameter int IDX_W  = 4,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 0,
    parameter int STAT_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [PC_W-1:0]   PRED_PC,
    output logic              PRED_TAKEN,
    output logic [IDX_W-1:0]  PRED_IDX,
    input  logic              RES_VALID,
    input  logic [IDX_W-1:0]  RES_IDX,
    input  logic [3:0]        BRANCH_TYPE,
    input  logic              C,
    input  logic              Z,
    input  logic              RES_PREDICTED,
    output logic              BRANCH_TAKEN,
    output logic              BRANCH_MISS,
    input  logic              CLR_STATS,
    output logic [STAT_W-1:0] BR_COUNT,
    output logic [STAT_W-1:0] MISS_COUNT
);

    localparam int DEPTH = 1 << IDX_W;
    // A one-bit history register is kept even in bimodal mode so the
    // shift logic stays uniform; its value is simply never used for indexing.
    localparam int GH_W  = (HIST_W > 0) ? HIST_W : 1;

    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

    localparam logic [3:0] BT_BRCC  = 4'h1;
    localparam logic [3:0] BT_BRCS  = 4'h2;
    localparam logic [3:0] BT_BREQ  = 4'h3;
    localparam logic [3:0] BT_BRN   = 4'h4;
    localparam logic [3:0] BT_BRNE  = 4'h5;
    localparam logic [3:0] BT_CALL  = 4'h6;
    localparam logic [3:0] BT_RET   = 4'h7;
    localparam logic [3:0] BT_RETID = 4'h8;
    localparam logic [3:0] BT_RETIE = 4'h9;

    logic [CTR_W-1:0] ctr_table [DEPTH];
    logic [GH_W-1:0]  ghr;
    logic [GH_W:0]    ghr_shift;
    logic [IDX_W-1:0] ghr_ext;
    logic             is_cond;
    logic             train;

    // Saturating up/down step of a prediction counter.
    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] cur,
                                                  input logic up);
        logic [CTR_W-1:0] nxt;
        nxt = cur;
        if (up) begin
            if (cur != {CTR_W{1'b1}}) nxt = cur + 1'b1;
        end else begin
            if (cur != '0) nxt = cur - 1'b1;
        end
        return nxt;
    endfunction

    // Saturating increment of a statistics counter.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] cur);
        return (cur == {STAT_W{1'b1}}) ? cur : cur + 1'b1;
    endfunction

    generate
        if (HIST_W > 0) begin : g_gshare
            assign ghr_ext = IDX_W'(ghr);
        end else begin : g_bimodal
            assign ghr_ext = '0;
        end
        if (PC_W > IDX_W) begin : g_pc_hi
            // Upper PC bits do not take part in indexing.
            logic unused_pc_hi;
            assign unused_pc_hi = ^PRED_PC[PC_W-1:IDX_W];
        end
    endgenerate

    // Predict: zero-latency read of the counter MSB.
    assign PRED_IDX   = PRED_PC[IDX_W-1:0] ^ ghr_ext;
    assign PRED_TAKEN = ctr_table[PRED_IDX][CTR_W-1];

    // Resolve: actual direction from branch type and flags.
    always_comb begin
        BRANCH_TAKEN = 1'b0;
        is_cond      = 1'b0;
        case (BRANCH_TYPE)
            BT_BRCC: begin BRANCH_TAKEN = ~C; is_cond = 1'b1; end
            BT_BRCS: begin BRANCH_TAKEN =  C; is_cond = 1'b1; end
            BT_BREQ: begin BRANCH_TAKEN =  Z; is_cond = 1'b1; end
            BT_BRNE: begin BRANCH_TAKEN = ~Z; is_cond = 1'b1; end
            BT_BRN, BT_CALL, BT_RET, BT_RETID, BT_RETIE: BRANCH_TAKEN = 1'b1;
            default: BRANCH_TAKEN = 1'b0;
        endcase
    end

    assign BRANCH_MISS = RES_VALID & (RES_PREDICTED ^ BRANCH_TAKEN);
    assign train       = RES_VALID & is_cond;
    // Shift the resolved direction into the history; the top bit drops out.
    assign ghr_shift   = {ghr, BRANCH_TAKEN};

    // Table and history training; only conditional branches train.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_table[i] <= CTR_INIT;
            end
            ghr <= '0;
        end else if (train) begin
            ctr_table[RES_IDX] <= ctr_step(ctr_table[RES_IDX], BRANCH_TAKEN);
            ghr                <= ghr_shift[GH_W-1:0];
        end
    end

    // Statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BR_COUNT   <= '0;
            MISS_COUNT <= '0;
        end else if (CLR_STATS) begin
            BR_COUNT   <= '0;
            MISS_COUNT <= '0;
        end else begin
            if (train)       BR_COUNT   <= sat_inc(BR_COUNT);
            if (BRANCH_MISS) MISS_COUNT <= sat_inc(MISS_COUNT);
        end
    end

endmodule
